// File: rtl/display_7seg_mux.sv
// Six-digit multiplexed 7-segment driver (hh.mm.ss) that takes a tear-free snapshot of its inputs once per scan frame.
// Define BLINK_SEP_EN to blink the separator dots every BLINK_FRAMES frames; if it is undefined they stay lit.
module display_7seg_mux #(
  parameter int unsigned SCAN_DIV     = 4,
  parameter int unsigned BLINK_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] H_in1,
  input  logic [3:0] H_in0,
  input  logic [3:0] M_in1,
  input  logic [3:0] M_in0,
  input  logic [3:0] S_in1,
  input  logic [3:0] S_in0,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = 3;
  localparam int unsigned SW = 24;
  localparam logic [PW-1:0] P_TERM   = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(5);

  if (SCAN_DIV < 2 || SCAN_DIV > 1024) begin : g_bad_scan_div
    $error("display_7seg_mux: SCAN_DIV must be 2..1024");
  end
  if (BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : g_bad_blink_frames
    $error("display_7seg_mux: BLINK_FRAMES must be 1..255");
  end

  logic [PW-1:0] r_presc;
  logic [IW-1:0] r_idx;
  logic [SW-1:0] r_snap;
  logic [5:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_frame_tick;

  logic          w_term;
  logic          w_frame_end;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg_dec;
  logic          w_blank;
  logic          w_sep_slot;
  logic          w_sep_on;

  assign w_term      = (r_presc == P_TERM);
  assign w_frame_end = en & w_term & (r_idx == LAST_IDX);

  // Prescaler, digit index and the once-per-frame input snapshot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_snap  <= '0;
    end else if (en) begin
      if (w_term) begin
        r_presc <= '0;
        r_idx   <= (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      if (w_frame_end) begin
        r_snap <= {2'b00, H_in1, H_in0, M_in1, M_in0, S_in1, S_in0};
      end
    end
  end

`ifdef BLINK_SEP_EN
  localparam int unsigned FW = 8;
  localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] r_frame_cnt;
  logic          r_phase;

  // Completed-frame counter; the separator phase flips on each wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (w_frame_end) begin
      if (r_frame_cnt == F_LAST) begin
        r_frame_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_frame_cnt <= r_frame_cnt + FW'(1);
      end
    end
  end

  assign w_sep_on = r_phase;
`else
  assign w_sep_on = 1'b1;
`endif

  // Select the snapshot digit for the current index and decode it
  always_comb begin
    w_digit    = 4'd0;
    w_seg_dec  = 7'h40;
    case (r_idx)
      3'd0:    w_digit = r_snap[3:0];
      3'd1:    w_digit = r_snap[7:4];
      3'd2:    w_digit = r_snap[11:8];
      3'd3:    w_digit = r_snap[15:12];
      3'd4:    w_digit = r_snap[19:16];
      3'd5:    w_digit = r_snap[23:20];
      default: w_digit = 4'd0;
    endcase
    case (w_digit)
      4'd0:    w_seg_dec = 7'h3F;
      4'd1:    w_seg_dec = 7'h06;
      4'd2:    w_seg_dec = 7'h5B;
      4'd3:    w_seg_dec = 7'h4F;
      4'd4:    w_seg_dec = 7'h66;
      4'd5:    w_seg_dec = 7'h6D;
      4'd6:    w_seg_dec = 7'h7D;
      4'd7:    w_seg_dec = 7'h07;
      4'd8:    w_seg_dec = 7'h7F;
      4'd9:    w_seg_dec = 7'h6F;
      default: w_seg_dec = 7'h40;
    endcase
    w_blank    = (r_idx == LAST_IDX) && (w_digit == 4'd0);
    w_sep_slot = (r_idx == IW'(2)) || (r_idx == IW'(4));
  end

  // Registered display outputs, one cycle behind the index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an         <= 6'b111111;
      r_seg        <= 7'h00;
      r_dp         <= 1'b0;
      r_frame_tick <= 1'b0;
    end else if (en) begin
      r_an         <= ~(6'b000001 << r_idx);
      r_seg        <= w_blank ? 7'h00 : w_seg_dec;
      r_dp         <= w_sep_slot & w_sep_on;
      r_frame_tick <= w_frame_end;
    end else begin
      r_an         <= 6'b111111;
      r_seg        <= 7'h00;
      r_dp         <= 1'b0;
      r_frame_tick <= 1'b0;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_tick = r_frame_tick;

endmodule
